// File: rtl/aes_pkg.sv
// Shared AES definitions: key length encoding, round/word counts, GF(2^8)
// helpers, the S-box, the round transforms and the controller state type.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_READY  = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } fsm_state_t;

    localparam logic [1:0] KEY_LEN_128     = 2'd0;
    localparam logic [1:0] KEY_LEN_192     = 2'd1;
    localparam logic [1:0] KEY_LEN_256     = 2'd2;
    localparam logic [1:0] KEY_LEN_ILLEGAL = 2'd3;

    // Number of rounds for a key length code.
    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEY_LEN_128: return 4'd10;
            KEY_LEN_192: return 4'd12;
            KEY_LEN_256: return 4'd14;
            default:     return 4'd10;
        endcase
    endfunction

    // Number of 32-bit key words for a key length code.
    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEY_LEN_128: return 4'd4;
            KEY_LEN_192: return 4'd6;
            KEY_LEN_256: return 4'd8;
            default:     return 4'd4;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? aa : 8'h00);
            aa  = xtime(aa);
        end
        return acc;
    endfunction

    // S-box: multiplicative inverse (x^254, so 0 maps to 0) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Next round constant: doubling in GF(2^8), 0x80 wraps to 0x1b.
    function automatic logic [7:0] rcon_next(input logic [7:0] r);
        return xtime(r);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Row r of the column-major state rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] x);
        logic [0:15][7:0] b;
        logic [0:15][7:0] o;
        b = x;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4*c+r] = b[4*((c+r)%4)+r];
            end
        end
        return o;
    endfunction

    // Each column multiplied by the fixed {02,03,01,01} circulant matrix.
    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [0:15][7:0] b;
        logic [0:15][7:0] o;
        b = x;
        for (int c = 0; c < 4; c++) begin
            o[4*c]   = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            o[4*c+1] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            o[4*c+2] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
            o[4*c+3] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Four parallel S-boxes applied to one 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                       sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128/192/256 encryptor: one-word-per-cycle key expansion into a
// round-key buffer, then one round per 16/SBOX_LANES cycles per block.
module aes_iter_cipher
    import aes_pkg::*;
#(
    parameter int SBOX_LANES   = 16,
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         key_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NR_MAX = (MAX_KEY_BITS >= 32'd256) ? 14 : ((MAX_KEY_BITS >= 32'd192) ? 12 : 10);
    localparam int NW     = 4 * (NR_MAX + 1);
    localparam int NSTEP  = 16 / SBOX_LANES;
    localparam int NG     = SBOX_LANES / 4;

    fsm_state_t        fsm_r;
    logic [31:0]       w_r [NW];
    logic [3:0]        nr_r;
    logic [3:0]        nk_r;
    logic [5:0]        widx_r;
    logic [3:0]        kmod_r;
    logic [7:0]        rcon_r;
    logic [0:3][31:0]  state_r;
    logic [0:3][31:0]  sub_r;
    logic [3:0]        round_r;
    logic [1:0]        cyc_r;
    logic [127:0]      out_data_r;
    logic              out_valid_r;
    logic              key_ready_r;
    logic              in_rdy_r;
    logic              busy_r;
    logic              key_err_r;

    logic              mode_ok_s;
    logic              key_fire_s;
    logic              in_fire_s;
    logic [31:0]       prev_s;
    logic [31:0]       far_s;
    logic [31:0]       ks_in_s;
    logic [31:0]       ks_out_s;
    logic [31:0]       temp_s;
    logic [1:0]        lane_idx_s [NG];
    logic [31:0]       lane_out_s [NG];
    logic [0:3][31:0]  sub_next_s;
    logic [127:0]      shifted_s;
    logic [127:0]      mixed_s;
    logic [127:0]      rk_s;
    logic [127:0]      rk0_s;
    logic [127:0]      round_out_s;
    logic              last_cyc_s;

    assign key_ready = key_ready_r;
    assign key_err   = key_err_r;
    // A key offered in READY wins over plaintext in the same cycle.
    assign in_ready  = in_rdy_r & ~key_valid;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

    assign mode_ok_s  = (key_len == KEY_LEN_128)
                     || ((key_len == KEY_LEN_192) && (MAX_KEY_BITS >= 32'd192))
                     || ((key_len == KEY_LEN_256) && (MAX_KEY_BITS >= 32'd256));
    assign key_fire_s = key_valid & key_ready_r;
    assign in_fire_s  = in_valid & in_ready;

    // Key schedule operands: previous word and the word Nk positions back.
    assign prev_s = w_r[widx_r - 6'd1];
    assign far_s  = w_r[widx_r - {2'b00, nk_r}];

    aes_subword u_key_sub (.word_in(ks_in_s), .word_out(ks_out_s));

    // Select the schedule transform for the word being generated.
    always_comb begin
        ks_in_s = (kmod_r == 4'd0) ? rot_word(prev_s) : prev_s;
        if (kmod_r == 4'd0) begin
            temp_s = ks_out_s ^ {rcon_r, 24'h000000};
        end else if ((nk_r == 4'd8) && (kmod_r == 4'd4)) begin
            temp_s = ks_out_s;
        end else begin
            temp_s = prev_s;
        end
    end

    // Datapath S-box lanes: each cycle covers the next NG state columns.
    for (genvar g = 0; g < NG; g++) begin : g_lane
        assign lane_idx_s[g] = 2'(int'(cyc_r) * NG + g);
        aes_subword u_lane_sub (.word_in(state_r[lane_idx_s[g]]), .word_out(lane_out_s[g]));
    end

    // Merge this cycle's substituted columns into the partial SubBytes result.
    always_comb begin
        sub_next_s = sub_r;
        for (int g = 0; g < NG; g++) begin
            sub_next_s[lane_idx_s[g]] = lane_out_s[g];
        end
    end

    assign rk0_s       = {w_r[0], w_r[1], w_r[2], w_r[3]};
    assign rk_s        = {w_r[{round_r, 2'd0}], w_r[{round_r, 2'd1}],
                          w_r[{round_r, 2'd2}], w_r[{round_r, 2'd3}]};
    assign shifted_s   = shift_rows(sub_next_s);
    assign mixed_s     = (round_r == nr_r) ? shifted_s : mix_columns(shifted_s);
    assign round_out_s = mixed_s ^ rk_s;
    assign last_cyc_s  = (cyc_r == 2'(NSTEP - 1));

    // Controller, key schedule buffer, round state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_r       <= ST_IDLE;
            for (int j = 0; j < NW; j++) begin
                w_r[j] <= 32'h0;
            end
            nr_r        <= 4'd0;
            nk_r        <= 4'd4;
            widx_r      <= 6'd0;
            kmod_r      <= 4'd0;
            rcon_r      <= 8'h01;
            state_r     <= '0;
            sub_r       <= '0;
            round_r     <= 4'd0;
            cyc_r       <= 2'd0;
            out_data_r  <= 128'h0;
            out_valid_r <= 1'b0;
            key_ready_r <= 1'b1;
            in_rdy_r    <= 1'b0;
            busy_r      <= 1'b0;
            key_err_r   <= 1'b0;
        end else begin
            key_err_r <= 1'b0;
            case (fsm_r)
                ST_IDLE, ST_READY: begin
                    if (key_fire_s && mode_ok_s) begin
                        for (int j = 0; j < 8; j++) begin
                            w_r[j] <= key[255 - 32*j -: 32];
                        end
                        nr_r        <= nr_of(key_len);
                        nk_r        <= nk_of(key_len);
                        widx_r      <= {2'b00, nk_of(key_len)};
                        kmod_r      <= 4'd0;
                        rcon_r      <= 8'h01;
                        fsm_r       <= ST_KEYEXP;
                        key_ready_r <= 1'b0;
                        in_rdy_r    <= 1'b0;
                        busy_r      <= 1'b1;
                    end else if (key_fire_s) begin
                        // Unusable key: any old schedule is dropped.
                        key_err_r   <= 1'b1;
                        fsm_r       <= ST_IDLE;
                        key_ready_r <= 1'b1;
                        in_rdy_r    <= 1'b0;
                    end else if (in_fire_s) begin
                        state_r     <= in_data ^ rk0_s;
                        round_r     <= 4'd1;
                        cyc_r       <= 2'd0;
                        fsm_r       <= ST_ROUND;
                        key_ready_r <= 1'b0;
                        in_rdy_r    <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        fsm_r <= fsm_r;
                    end
                end
                ST_KEYEXP: begin
                    w_r[widx_r] <= far_s ^ temp_s;
                    widx_r      <= widx_r + 6'd1;
                    kmod_r      <= (kmod_r == nk_r - 4'd1) ? 4'd0 : kmod_r + 4'd1;
                    rcon_r      <= (kmod_r == 4'd0) ? rcon_next(rcon_r) : rcon_r;
                    if (widx_r == {nr_r, 2'b11}) begin
                        fsm_r       <= ST_READY;
                        key_ready_r <= 1'b1;
                        in_rdy_r    <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        fsm_r <= ST_KEYEXP;
                    end
                end
                ST_ROUND: begin
                    sub_r <= sub_next_s;
                    if (last_cyc_s) begin
                        cyc_r   <= 2'd0;
                        state_r <= round_out_s;
                        round_r <= round_r + 4'd1;
                        if (round_r == nr_r) begin
                            out_data_r  <= round_out_s;
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b0;
                            fsm_r       <= ST_DONE;
                        end else begin
                            fsm_r <= ST_ROUND;
                        end
                    end else begin
                        cyc_r <= cyc_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        key_ready_r <= 1'b1;
                        in_rdy_r    <= 1'b1;
                        fsm_r       <= ST_READY;
                    end else begin
                        fsm_r <= ST_DONE;
                    end
                end
                default: begin
                    fsm_r       <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    key_ready_r <= 1'b1;
                    in_rdy_r    <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Self-checking bench: FIPS-197 vectors, randomized keys/blocks against a
// byte-level reference model, backpressure, key priority, illegal modes and
// asynchronous reset. Instance 0: 16 lanes / 256-bit max; instance 1: 4 lanes / 128-bit max.
module tb_aes_iter_cipher;

    logic         clk = 1'b0;
    logic         reset;
    logic         kv   [2];
    logic         kr   [2];
    logic [1:0]   kl   [2];
    logic [255:0] kd   [2];
    logic         ke   [2];
    logic         iv   [2];
    logic         ir   [2];
    logic [127:0] id   [2];
    logic         ov   [2];
    logic         ordy [2];
    logic [127:0] od   [2];
    logic         bz   [2];

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    aes_iter_cipher #(.SBOX_LANES(16), .MAX_KEY_BITS(256)) dut (
        .clk(clk), .reset(reset),
        .key_valid(kv[0]), .key_ready(kr[0]), .key_len(kl[0]), .key(kd[0]), .key_err(ke[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0])
    );

    aes_iter_cipher #(.SBOX_LANES(4), .MAX_KEY_BITS(128)) dut4 (
        .clk(clk), .reset(reset),
        .key_valid(kv[1]), .key_ready(kr[1]), .key_len(kl[1]), .key(kd[1]), .key_err(ke[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1])
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Textbook AES encryption over byte arrays; nk = 4/6/8 key words.
    function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk, input logic [127:0] pt);
        logic [7:0] w [240];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a [4];
        logic [7:0] rc [10];
        logic [7:0] first;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4*nk; i++) w[i] = k[255-8*i -: 8];
        for (int i = nk; i < 4*(nr+1); i++) begin
            for (int j = 0; j < 4; j++) a[j] = w[4*(i-1)+j];
            if (i % nk == 0) begin
                first = a[0];
                a[0] = sb[a[1]] ^ rc[i/nk-1];
                a[1] = sb[a[2]];
                a[2] = sb[a[3]];
                a[3] = sb[first];
            end else if (nk == 8 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) a[j] = sb[a[j]];
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-nk)+j] ^ a[j];
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b];
        for (int r = 1; r <= nr; r++) begin
            for (int b = 0; b < 16; b++) s[b] = sb[s[b]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
                for (int j = 0; j < 4; j++) begin
                    if (r < nr)
                        s[4*c+j] = xt(a[j]) ^ xt(a[(j+1)%4]) ^ a[(j+1)%4] ^ a[(j+2)%4] ^ a[(j+3)%4];
                    else
                        s[4*c+j] = a[j];
                end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[16*r+b];
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_key(input int d, input logic [255:0] k, input logic [1:0] len, input int exp_cyc);
        int n;
        @(negedge clk);
        chk1("key_ready_before_load", kr[d], 1'b1);
        kv[d] = 1'b1; kd[d] = k; kl[d] = len;
        @(negedge clk);
        kv[d] = 1'b0; kd[d] = {rnd128(), rnd128()};
        chk1("keyexp_busy", bz[d], 1'b1);
        chk1("keyexp_in_ready_low", ir[d], 1'b0);
        n = 0;
        while (!ir[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_int("keyexp_cycles", n, exp_cyc);
    endtask

    task automatic encrypt(input int d, input logic [127:0] pt, input logic [127:0] exp,
                           input int exp_lat, input int hold);
        int n;
        @(negedge clk);
        chk1("in_ready_before_block", ir[d], 1'b1);
        iv[d] = 1'b1; id[d] = pt;
        @(negedge clk);
        iv[d] = 1'b0; id[d] = rnd128();
        n = 0;
        while (!ov[d] && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk_int("out_latency", n, exp_lat);
        chk128("ciphertext", od[d], exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk1("hold_out_valid", ov[d], 1'b1);
            chk128("hold_out_data", od[d], exp);
            chk1("hold_in_ready_low", ir[d], 1'b0);
            chk1("hold_key_ready_low", kr[d], 1'b0);
        end
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        chk1("out_valid_after_handshake", ov[d], 1'b0);
        chk1("in_ready_after_handshake", ir[d], 1'b1);
    endtask

    task automatic illegal_key(input int d, input logic [1:0] len);
        @(negedge clk);
        kv[d] = 1'b1; kl[d] = len; kd[d] = {rnd128(), rnd128()};
        @(negedge clk);
        kv[d] = 1'b0;
        chk1("key_err_pulse", ke[d], 1'b1);
        chk1("key_err_key_ready", kr[d], 1'b1);
        chk1("key_err_in_ready", ir[d], 1'b0);
        chk1("key_err_busy", bz[d], 1'b0);
        @(negedge clk);
        chk1("key_err_single", ke[d], 1'b0);
        chk1("key_err_in_ready_after", ir[d], 1'b0);
        chk1("key_err_busy_after", bz[d], 1'b0);
    endtask

    initial begin
        logic [7:0] p, q, x;
        logic [255:0] k;
        logic [127:0] pt;
        int len;
        localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        localparam logic [255:0] KFIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;

        // S-box table from generator 3 and its inverse walk.
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;

        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            kv[d] = 1'b0; kl[d] = 2'd0; kd[d] = '0; iv[d] = 1'b0; id[d] = '0; ordy[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk1("rst_key_ready", kr[0], 1'b1);
        chk1("rst_key_err", ke[0], 1'b0);
        chk1("rst_in_ready", ir[0], 1'b0);
        chk1("rst_out_valid", ov[0], 1'b0);
        chk128("rst_out_data", od[0], 128'h0);
        chk1("rst_busy", bz[0], 1'b0);
        chk1("rst_key_ready_l4", kr[1], 1'b1);
        reset = 1'b1;

        illegal_key(0, 2'd3);
        illegal_key(1, 2'd2);

        load_key(0, K128, 2'd0, 40);
        encrypt(0, PT0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10, 0);
        load_key(0, K192, 2'd1, 46);
        encrypt(0, PT0, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12, 0);
        load_key(0, K256, 2'd2, 52);
        encrypt(0, PT0, 128'h8ea2b7ca516745bfeafc49904b496089, 14, 0);

        load_key(0, KFIPS, 2'd0, 40);
        encrypt(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 10, 7);
        encrypt(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 10, 0);

        for (int it = 0; it < 5; it++) begin
            len = int'($urandom_range(2, 0));
            k = {rnd128(), rnd128()};
            load_key(0, k, 2'(len), 40 + 6*len);
            for (int b = 0; b < 2; b++) begin
                pt = rnd128();
                encrypt(0, pt, aes_ref(k, 4 + 2*len, pt), 10 + 2*len, int'($urandom_range(3, 0)));
            end
        end

        // Key and plaintext together in READY: key wins, block is dropped.
        k = {rnd128(), rnd128()};
        @(negedge clk);
        kv[0] = 1'b1; kd[0] = k; kl[0] = 2'd0; iv[0] = 1'b1; id[0] = rnd128();
        #1;
        chk1("prio_in_ready_low", ir[0], 1'b0);
        @(negedge clk);
        kv[0] = 1'b0; iv[0] = 1'b0;
        chk1("prio_busy", bz[0], 1'b1);
        chk1("prio_key_ready_low", kr[0], 1'b0);
        len = 0;
        while (!ir[0] && len < 200) begin
            @(negedge clk);
            len++;
        end
        chk_int("prio_keyexp_cycles", len, 40);
        chk1("prio_no_output", ov[0], 1'b0);
        pt = rnd128();
        encrypt(0, pt, aes_ref(k, 4, pt), 10, 0);

        // Reset in the middle of a block.
        @(negedge clk);
        iv[0] = 1'b1; id[0] = rnd128();
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk1("pre_reset_busy", bz[0], 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("mid_rst_key_ready", kr[0], 1'b1);
        chk1("mid_rst_key_err", ke[0], 1'b0);
        chk1("mid_rst_in_ready", ir[0], 1'b0);
        chk1("mid_rst_out_valid", ov[0], 1'b0);
        chk128("mid_rst_out_data", od[0], 128'h0);
        chk1("mid_rst_busy", bz[0], 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk1("post_rst_in_ready", ir[0], 1'b0);
        chk1("post_rst_out_valid", ov[0], 1'b0);
        illegal_key(0, 2'd3);
        k = {rnd128(), rnd128()};
        load_key(0, k, 2'd2, 52);
        pt = rnd128();
        encrypt(0, pt, aes_ref(k, 8, pt), 14, 2);

        // Four-lane, 128-bit-only instance.
        illegal_key(1, 2'd2);
        load_key(1, K128, 2'd0, 40);
        encrypt(1, PT0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 40, 3);
        pt = rnd128();
        encrypt(1, pt, aes_ref(K128, 4, pt), 40, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_iter_cipher.md
Name: aes_iter_cipher

Overview:
Iterative, parametrised AES-128/192/256 encryption core with valid/ready handshakes on the key, plaintext and ciphertext paths. A key is loaded once and expanded into an internal round-key buffer, one word per cycle. Any number of blocks are then encrypted against that buffer, one round per 16/SBOX_LANES cycles. It supersedes the single-mode, handshake-less cipher FSM and sits between the host block buffer and the output framer.

Parameters:
SBOX_LANES, 16, S-box instances in the datapath; legal values are 4 and 16. A round takes 16/SBOX_LANES cycles.
MAX_KEY_BITS, 256, largest supported key (128/192/256). It sizes the schedule buffer to 4*(Nr_max+1) words. Modes above it are rejected.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
key_valid  input  1  key/key_len are valid
key_ready  output  1  core can accept a key
key_len  input  2  0=128, 1=192, 2=256, 3=illegal
key  input  256  cipher key, MSB-first FIPS byte order, left-justified (128-bit key in [255:128], 192-bit in [255:64])
key_err  output  1  one-cycle pulse: illegal or unsupported key_len accepted
in_valid  input  1  plaintext valid
in_ready  output  1  core can accept plaintext
in_data  input  128  plaintext, byte 0 in [127:120]
out_valid  output  1  ciphertext valid
out_ready  input  1  downstream accepts ciphertext
out_data  output  128  ciphertext
busy  output  1  high in KEYEXP or ROUND

Behaviour:
- Reset values: key_ready=1, key_err=0, in_ready=0, out_valid=0, out_data=0, busy=0. FSM=IDLE, schedule marked invalid.
- Reset asserted mid-operation aborts immediately. Schedule and state are discarded, and no partial output is ever presented.
- FSM states: IDLE, KEYEXP, READY, ROUND, DONE.
- IDLE: key_ready=1. A key is accepted on key_valid&&key_ready.
  - Legal mode: latch Nk words into buffer words 0..Nk-1, set Nr=10/12/14, go to KEYEXP.
  - Illegal mode (3, or above MAX_KEY_BITS): key_err pulses the next cycle and the FSM stays in IDLE.
- KEYEXP: generates word i, from Nk up to 4*(Nr+1)-1, one per cycle.
  - W[i-1] is RotWord+SubWord+Rcon when i mod Nk==0.
  - For Nk==8 only, W[i-1] is SubWord when i mod Nk==4.
  - W[i] = W[i-Nk] xor the above.
  - Rcon starts at 0x01 and is doubled in GF(2^8), so 0x80 is followed by 0x1b.
  - Takes 40/46/52 cycles for 128/192/256, then goes to READY.
  - key_ready=0 and in_ready=0 throughout.
- READY: in_ready=1 and key_ready=1.
  - A new key has priority over plaintext presented in the same cycle. The old schedule is discarded and the FSM goes to KEYEXP; in_ready is low in that cycle, so the plaintext is not accepted.
  - Plaintext accept: state <= in_data xor RK0, round=1, go to ROUND.
- ROUND: each round takes 16/SBOX_LANES cycles.
  - Each cycle substitutes SBOX_LANES bytes into a sub-buffer.
  - The final cycle of the round applies ShiftRows, then MixColumns (skipped when round==Nr), then AddRoundKey with RK[round], and increments round.
  - After round Nr: out_data <= state, out_valid=1, go to DONE.
  - Latency: out_valid rises Nr*16/SBOX_LANES cycles after the accept edge (10 cycles for AES-128 with 16 lanes).
- DONE: out_valid and out_data held stable until out_ready. On the handshake edge: out_valid=0, go to READY. in_ready=0 and key_ready=0 while in DONE.
- key/in_data may change freely after their handshake cycle; the core holds internal copies.
- The schedule persists across blocks until the next key or reset.

Decomposition:
- Shared package aes_pkg holds:
  - key_len encoding constants;
  - Nr and Nk per mode;
  - the S-box function/table;
  - xtime/GF multiply function;
  - Rcon next-value function;
  - the FSM state typedef.
- Sub-module aes_subword: 4 parallel S-boxes on one 32-bit word. It is instantiated once for KEYEXP and SBOX_LANES/4 times in the datapath.

Test Plan:
- AES-128: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. KEYEXP lasts 40 cycles; out_valid rises 10 cycles after accept with SBOX_LANES=16, and 40 cycles with SBOX_LANES=4.
- AES-192: key 000102..1617, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191. AES-256: key 000102..1e1f -> 8ea2b7ca516745bfeafc49904b496089, with KEYEXP lasting 52 cycles.
- Key reuse and backpressure: key 2b7e151628aed2a6abf7158809cf4f3c, then pt 3243f6a8885a308d313198a2e0370734 twice.
  - Both outputs are 3925841d02dc09fbdc118597196a0b32.
  - Holding out_ready=0 for 7 cycles keeps out_data stable, with in_ready=0.
- key_len=3, or key_len=2 with MAX_KEY_BITS=128 -> key_err single pulse; FSM stays IDLE; in_ready stays 0.
- Simultaneous key_valid and in_valid in READY -> key accepted, plaintext not accepted (in_ready=0), KEYEXP entered.
- reset driven low mid-ROUND -> outputs at reset values within the same cycle; after release, in_ready stays 0 until a key is reloaded.
